// File: rtl/approx_adder_tree_pipe_if.sv
// approx_adder_tree_pipe_if
// Stream bundle for the pipelined approximate adder tree.
//   in_data   : N_IN packed operands, operand i = in_data[i*W +: W]
//   in_mode   : 0 = exact, 1 = approximate, sampled with in_data
//   in_valid  : input sample valid
//   in_ready  : tree can accept a sample this cycle
//   out_sum   : tree result, W+log2(N_IN) bits
//   out_mode  : mode the result was computed with
//   out_valid : out_sum/out_mode valid
//   out_ready : downstream accepts the output
// The tree itself uses the slave modport; a producer/consumer uses master.
interface approx_adder_tree_pipe_if #(
  parameter int N_IN = 8,
  parameter int W    = 8
);
  localparam int LEVELS = $clog2(N_IN);

  logic [N_IN*W-1:0]   in_data;
  logic                in_mode;
  logic                in_valid;
  logic                in_ready;
  logic [W+LEVELS-1:0] out_sum;
  logic                out_mode;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_sum, out_mode, out_valid
  );

  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_sum, out_mode, out_valid
  );
endinterface

// File: rtl/approx_adder_tree_pipe.sv
// approx_adder_tree_pipe
// Fully pipelined N_IN-input unsigned adder tree. Each sample carries a mode
// bit selecting exact addition or lower-part-OR approximate addition, where
// the APX_BITS low bits of every pair sum are the OR of the operand bits and
// only the upper bits are added (no carry out of the low part).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (0 = reset)
//   bus : approx_adder_tree_pipe_if slave (in_* / out_* valid-ready streams)
// One register stage per tree level, so latency is log2(N_IN) cycles. The
// whole pipeline advances together whenever the output slot is free or being
// consumed; bubbles are not squeezed out.
module approx_adder_tree_pipe #(
  parameter int N_IN     = 8,
  parameter int W        = 8,
  parameter int APX_BITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  approx_adder_tree_pipe_if.slave  bus
);
  localparam int LEVELS = $clog2(N_IN);

  logic adv;

  // Global advance: the last stage is empty or is being taken this cycle.
  assign adv          = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
    // Level lv reduces CNT pairs of WI-bit values into CNT values of WI+1 bits.
    localparam int CNT = N_IN >> lv;
    localparam int WI  = W + lv - 1;
    localparam int K   = (APX_BITS < WI) ? APX_BITS : WI;

    logic [CNT*2*WI-1:0]  src;
    logic                 src_valid;
    logic                 src_mode;
    logic [CNT*(WI+1)-1:0] sum_d;
    logic [CNT*(WI+1)-1:0] sum_q;
    logic                 valid_q;
    logic                 mode_q;

    // The first level is fed straight from the input port; later levels
    // take the registered partial sums of the level before them.
    if (lv == 1) begin : g_src
      assign src       = bus.in_data;
      assign src_valid = bus.in_valid;
      assign src_mode  = bus.in_mode;
    end else begin : g_src
      assign src       = g_lvl[lv-1].sum_q;
      assign src_valid = g_lvl[lv-1].valid_q;
      assign src_mode  = g_lvl[lv-1].mode_q;
    end

    for (genvar j = 0; j < CNT; j++) begin : g_pair
      logic [WI-1:0] x;
      logic [WI-1:0] y;
      logic [WI:0]   exact_sum;
      logic [WI:0]   apx_sum;

      assign x         = src[(2*j)*WI +: WI];
      assign y         = src[(2*j+1)*WI +: WI];
      assign exact_sum = {1'b0, x} + {1'b0, y};

      // The approximate low part never produces a carry, so when every bit
      // is approximated the top result bit is simply 0.
      if (K == 0) begin : g_apx
        assign apx_sum = exact_sum;
      end else if (K == WI) begin : g_apx
        assign apx_sum = {1'b0, x | y};
      end else begin : g_apx
        assign apx_sum = {{1'b0, x[WI-1:K]} + {1'b0, y[WI-1:K]},
                          x[K-1:0] | y[K-1:0]};
      end

      assign sum_d[j*(WI+1) +: WI+1] = src_mode ? apx_sum : exact_sum;
    end

    // Stage register: loads from the previous level on a global advance,
    // otherwise holds so the whole tree stalls in lock-step.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sum_q   <= '0;
        valid_q <= 1'b0;
        mode_q  <= 1'b0;
      end else if (adv) begin
        sum_q   <= sum_d;
        valid_q <= src_valid;
        mode_q  <= src_mode;
      end
    end
  end

  assign bus.out_sum   = g_lvl[LEVELS].sum_q;
  assign bus.out_valid = g_lvl[LEVELS].valid_q;
  assign bus.out_mode  = g_lvl[LEVELS].mode_q;

endmodule
